// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the fetch PC, requests words from instruction
// memory, buffers them with their addresses and handles redirects from downstream.
module fetch_unit #(
    parameter int                    ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = 32'h0000_0000,
    parameter int                    DEPTH      = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic                  imem_req,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    input  logic                  imem_ack,
    input  logic [31:0]           imem_rdata,
    output logic                  instr_valid,
    output logic [31:0]           instr,
    output logic [ADDR_WIDTH-1:0] instr_pc,
    input  logic                  instr_ready,
    input  logic                  redirect,
    input  logic [ADDR_WIDTH-1:0] redirect_pc
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FETCH   = 2'd1,
        DISCARD = 2'd2
    } state_t;

    state_t                  state_r;
    state_t                  state_next_s;
    logic [ADDR_WIDTH-1:0]   fetch_pc_r;
    logic [ADDR_WIDTH-1:0]   fetch_pc_next_s;
    logic [ADDR_WIDTH-1:0]   pending_r;
    logic [ADDR_WIDTH-1:0]   pending_next_s;
    logic [ADDR_WIDTH-1:0]   target_s;
    logic [CW-1:0]           count_r;
    logic [CW-1:0]           count_next_s;
    logic [PW-1:0]           rd_ptr_r;
    logic [PW-1:0]           wr_ptr_r;
    logic                    push_s;
    logic                    pop_s;
    logic                    has_room_s;
    logic                    imem_req_r;
    logic [ADDR_WIDTH-1:0]   imem_addr_r;
    logic                    instr_valid_r;
    logic [31:0]             mem_instr_r [DEPTH];
    logic [ADDR_WIDTH-1:0]   mem_pc_r    [DEPTH];

    // Handshake qualification and FIFO occupancy after this cycle.
    always_comb begin
        target_s     = redirect_pc & ~{{(ADDR_WIDTH-2){1'b0}}, 2'b11};
        push_s       = (state_r == FETCH) && imem_ack && !redirect;
        pop_s        = (count_r != {CW{1'b0}}) && instr_ready && !redirect;
        count_next_s = count_r;
        if (redirect) begin
            count_next_s = {CW{1'b0}};
        end else begin
            count_next_s = count_r + {{(CW-1){1'b0}}, push_s} - {{(CW-1){1'b0}}, pop_s};
        end
        has_room_s = (count_next_s < CW'(DEPTH));
    end

    // Next-state, fetch PC and pending-redirect logic.
    always_comb begin
        state_next_s    = state_r;
        fetch_pc_next_s = fetch_pc_r;
        pending_next_s  = pending_r;
        case (state_r)
            IDLE: begin
                if (redirect) begin
                    fetch_pc_next_s = target_s;
                    state_next_s    = FETCH;
                end else if (has_room_s) begin
                    state_next_s = FETCH;
                end else begin
                    state_next_s = IDLE;
                end
            end
            FETCH: begin
                if (imem_ack && redirect) begin
                    fetch_pc_next_s = target_s;
                    state_next_s    = FETCH;
                end else if (imem_ack) begin
                    fetch_pc_next_s = fetch_pc_r + ADDR_WIDTH'(3'd4);
                    state_next_s    = has_room_s ? FETCH : IDLE;
                end else if (redirect) begin
                    // Request cannot be withdrawn: wait out its ack in DISCARD.
                    pending_next_s = target_s;
                    state_next_s   = DISCARD;
                end else begin
                    state_next_s = FETCH;
                end
            end
            DISCARD: begin
                if (imem_ack) begin
                    fetch_pc_next_s = redirect ? target_s : pending_r;
                    state_next_s    = FETCH;
                end else if (redirect) begin
                    pending_next_s = target_s;
                end else begin
                    state_next_s = DISCARD;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // Control state and registered memory-side outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= IDLE;
            fetch_pc_r    <= RESET_PC;
            pending_r     <= {ADDR_WIDTH{1'b0}};
            count_r       <= {CW{1'b0}};
            rd_ptr_r      <= {PW{1'b0}};
            wr_ptr_r      <= {PW{1'b0}};
            imem_req_r    <= 1'b0;
            imem_addr_r   <= {ADDR_WIDTH{1'b0}};
            instr_valid_r <= 1'b0;
        end else begin
            state_r       <= state_next_s;
            fetch_pc_r    <= fetch_pc_next_s;
            pending_r     <= pending_next_s;
            count_r       <= count_next_s;
            imem_req_r    <= (state_next_s != IDLE);
            instr_valid_r <= (count_next_s != {CW{1'b0}});
            if (state_next_s == FETCH) begin
                imem_addr_r <= fetch_pc_next_s;
            end else begin
                imem_addr_r <= imem_addr_r;
            end
            if (redirect) begin
                rd_ptr_r <= {PW{1'b0}};
                wr_ptr_r <= {PW{1'b0}};
            end else begin
                rd_ptr_r <= rd_ptr_r + {{(PW-1){1'b0}}, pop_s};
                wr_ptr_r <= wr_ptr_r + {{(PW-1){1'b0}}, push_s};
            end
        end
    end

    // FIFO storage: instruction word and its address per slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_instr_r[i] <= 32'h0000_0000;
                mem_pc_r[i]    <= {ADDR_WIDTH{1'b0}};
            end
        end else if (push_s) begin
            mem_instr_r[wr_ptr_r] <= imem_rdata;
            mem_pc_r[wr_ptr_r]    <= fetch_pc_r;
        end else begin
            mem_instr_r[wr_ptr_r] <= mem_instr_r[wr_ptr_r];
            mem_pc_r[wr_ptr_r]    <= mem_pc_r[wr_ptr_r];
        end
    end

    assign imem_req    = imem_req_r;
    assign imem_addr   = imem_addr_r;
    assign instr_valid = instr_valid_r;
    assign instr       = mem_instr_r[rd_ptr_r];
    assign instr_pc    = mem_pc_r[rd_ptr_r];

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a latency-configurable memory model drives the
// main instance; a second instance with a high RESET_PC checks PC wrap-around.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req, imem_ack, instr_valid, instr_ready, redirect;
    logic [31:0] imem_addr, imem_rdata, instr, instr_pc, redirect_pc;
    logic        w_req, w_valid;
    logic [31:0] w_addr, w_instr, w_pc;
    int          lat = 1;
    int          wcnt = 0;
    int          n_checks = 0;
    int          n_pass = 0;
    int          seen8;

    always #5 clk = ~clk;

    assign imem_ack   = imem_req && (wcnt == lat - 1);
    assign imem_rdata = imem_addr ^ 32'hE000_0000;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n || imem_ack) wcnt <= 0;
        else if (imem_req)      wcnt <= wcnt + 1;
    end

    fetch_unit dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc),
        .instr_ready(instr_ready),
        .redirect(redirect), .redirect_pc(redirect_pc)
    );

    fetch_unit #(.RESET_PC(32'hFFFF_FFF8)) u_wrap (
        .clk(clk), .rst_n(rst_n),
        .imem_req(w_req), .imem_addr(w_addr),
        .imem_ack(w_req), .imem_rdata(w_addr ^ 32'hE000_0000),
        .instr_valid(w_valid), .instr(w_instr), .instr_pc(w_pc),
        .instr_ready(1'b1),
        .redirect(1'b0), .redirect_pc(32'h0000_0000)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
        else             n_pass++;
    endtask

    // Leaves rst_n released just after a negedge; next negedge is cycle 1.
    task automatic do_reset(input int l, input logic rdy);
        @(negedge clk);
        rst_n = 1'b0; lat = l; instr_ready = rdy; redirect = 1'b0; redirect_pc = 32'h0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        instr_ready = 1'b1; redirect = 1'b0; redirect_pc = 32'h0;

        // Reset state and zero-wait streaming
        do_reset(1, 1'b1);
        rst_n = 1'b0; #1;
        check_eq("rst_req",   {31'd0, imem_req}, 32'd0);
        check_eq("rst_addr",  imem_addr, 32'd0);
        check_eq("rst_valid", {31'd0, instr_valid}, 32'd0);
        check_eq("rst_instr", instr, 32'd0);
        check_eq("rst_pc",    instr_pc, 32'd0);
        check_eq("rst_waddr", w_addr, 32'd0);
        do_reset(1, 1'b1);
        @(negedge clk);
        check_eq("c1_req",  {31'd0, imem_req}, 32'd1);
        check_eq("c1_addr", imem_addr, 32'd0);
        check_eq("c1_valid", {31'd0, instr_valid}, 32'd0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check_eq("str_valid", {31'd0, instr_valid}, 32'd1);
            check_eq("str_pc",    instr_pc, 32'(4 * k));
            check_eq("str_instr", instr, 32'(4 * k) ^ 32'hE000_0000);
        end

        // Backpressure: FIFO fills at two entries, then drains in order
        do_reset(1, 1'b0);
        repeat (3) @(negedge clk);
        check_eq("bp_req_c3", {31'd0, imem_req}, 32'd0);
        repeat (3) @(negedge clk);
        check_eq("bp_req_c6", {31'd0, imem_req}, 32'd0);
        check_eq("bp_valid",  {31'd0, instr_valid}, 32'd1);
        check_eq("bp_head",   instr_pc, 32'h0);
        @(negedge clk);
        instr_ready = 1'b1;
        check_eq("bp_pc0", instr_pc, 32'h0);
        @(negedge clk);
        check_eq("bp_pc4",  instr_pc, 32'h4);
        check_eq("bp_rereq", {31'd0, imem_req}, 32'd1);
        check_eq("bp_addr8", imem_addr, 32'h8);
        @(negedge clk);
        check_eq("bp_pc8",  instr_pc, 32'h8);
        check_eq("bp_v8",   {31'd0, instr_valid}, 32'd1);

        // Redirect while a 3-cycle request is outstanding
        do_reset(3, 1'b1);
        repeat (7) @(negedge clk);
        check_eq("rd_addr8", imem_addr, 32'h8);
        @(negedge clk);
        redirect = 1'b1; redirect_pc = 32'h100;
        @(negedge clk);
        redirect = 1'b0;
        check_eq("rd_flush", {31'd0, instr_valid}, 32'd0);
        check_eq("rd_hold",  imem_addr, 32'h8);
        seen8 = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (k == 0) check_eq("rd_newaddr", imem_addr, 32'h100);
            if (instr_valid && instr_pc == 32'h8) seen8++;
        end
        check_eq("rd_no8",   32'(seen8), 32'd0);
        check_eq("rd_first", instr_pc, 32'h100);
        check_eq("rd_finst", instr, 32'hE000_0100);

        // Redirect with ack and pop in the same cycle
        do_reset(1, 1'b1);
        repeat (3) @(negedge clk);
        check_eq("rap_pre", {31'd0, instr_valid & imem_req}, 32'd1);
        redirect = 1'b1; redirect_pc = 32'h203;
        @(negedge clk);
        redirect = 1'b0;
        check_eq("rap_empty", {31'd0, instr_valid}, 32'd0);
        check_eq("rap_addr",  imem_addr, 32'h200);
        @(negedge clk);
        check_eq("rap_pc",    instr_pc, 32'h200);
        check_eq("rap_instr", instr, 32'hE000_0200);

        // Redirects while discarding; the one on the ack cycle wins
        do_reset(3, 1'b1);
        @(negedge clk);
        redirect = 1'b1; redirect_pc = 32'h20;
        @(negedge clk);
        redirect_pc = 32'h40;
        check_eq("dis_hold2", imem_addr, 32'h0);
        @(negedge clk);
        redirect_pc = 32'h80;
        check_eq("dis_hold3", imem_addr, 32'h0);
        @(negedge clk);
        redirect = 1'b0;
        check_eq("dis_addr", imem_addr, 32'h80);
        repeat (3) @(negedge clk);
        check_eq("dis_valid", {31'd0, instr_valid}, 32'd1);
        check_eq("dis_pc",    instr_pc, 32'h80);

        // Wrap-around from a high reset PC, then async reset mid-stream
        do_reset(1, 1'b1);
        @(negedge clk);
        check_eq("w_c1addr", w_addr, 32'hFFFF_FFF8);
        @(negedge clk);
        check_eq("w_pc0", w_pc, 32'hFFFF_FFF8);
        @(negedge clk);
        check_eq("w_pc1", w_pc, 32'hFFFF_FFFC);
        @(negedge clk);
        check_eq("w_pc2", w_pc, 32'h0000_0000);
        check_eq("w_ins2", w_instr, 32'hE000_0000);
        #2 rst_n = 1'b0;
        #1;
        check_eq("ar_wreq",   {31'd0, w_req}, 32'd0);
        check_eq("ar_waddr",  w_addr, 32'd0);
        check_eq("ar_wvalid", {31'd0, w_valid}, 32'd0);
        check_eq("ar_wpc",    w_pc, 32'd0);
        check_eq("ar_winstr", w_instr, 32'd0);
        check_eq("ar_req",    {31'd0, imem_req}, 32'd0);
        check_eq("ar_pc",     instr_pc, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("ar_restart", w_addr, 32'hFFFF_FFF8);
        check_eq("ar_rreq",    {31'd0, w_req}, 32'd1);
        @(negedge clk);
        check_eq("ar_rpc",     w_pc, 32'hFFFF_FFF8);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
